// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash reader: FSM states, spi_master register
// map, status bit positions and the flash READ opcode.
package spi_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CS_ON,
        S_WAIT_TX,
        S_SEND,
        S_FLUSH,
        S_WAIT_RX,
        S_READ,
        S_EMIT,
        S_CS_OFF,
        S_DONE
    } state_t;

    // spi_master register offsets (one address bit on the slave port)
    localparam logic SPI_ADR_DATA = 1'b0;
    localparam logic SPI_ADR_CTRL = 1'b1;

    // spi_master status register bits
    localparam int ST_RXRDY  = 0;
    localparam int ST_TXBUSY = 1;

    // Serial NOR flash slow-read opcode
    localparam logic [7:0] OP_READ = 8'h03;

    // Byte lanes: ctrl writes touch selects + conf, data writes touch the tx byte
    localparam logic [3:0] SEL_CTRL = 4'b1100;
    localparam logic [3:0] SEL_DATA = 4'b0001;

    localparam logic [7:0] CS_ALL_OFF = 8'hff;

    // Ctrl register layout: {selects (active low), conf, reserved}
    function automatic logic [31:0] ctrl_word(input logic [7:0] selects, input logic [7:0] conf);
        return {selects, conf, 16'h0000};
    endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// Wishbone master port toward the spi_master slave (or the bus arbiter).
interface spi_flash_reader_if;

    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic        m_adr_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i;

    modport master (
        output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o,
        input  m_dat_i, m_ack_i
    );

    modport slave (
        input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o,
        output m_dat_i, m_ack_i
    );

endinterface

// File: rtl/spi_wb_access.sv
// Single-access Wishbone master. A go pulse while idle launches one registered
// cycle; the cycle holds until ack, drops the next clock, and done_o pulses
// together with the captured read data.
module spi_wb_access (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      go_i,
    input  logic                      we_i,
    input  logic                      adr_i,
    input  logic [3:0]                sel_i,
    input  logic [31:0]               dat_i,
    output logic [31:0]               rdata_o,
    output logic                      done_o,
    output logic                      busy_o,
    spi_flash_reader_if.master        wb
);

    logic        cyc_q;
    logic        we_q;
    logic        adr_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic [31:0] rdata_q;
    logic        done_q;

    // Launch, hold and retire one bus access; all bus outputs idle at 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 1'b0;
            sel_q   <= 4'h0;
            dat_q   <= 32'h0;
            rdata_q <= 32'h0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to the
            // same edge, so reads of cyc_q below see the pre-edge value.
            done_q <= 1'b0;
            if (cyc_q) begin
                if (wb.m_ack_i) begin
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                    adr_q   <= 1'b0;
                    sel_q   <= 4'h0;
                    dat_q   <= 32'h0;
                    rdata_q <= wb.m_dat_i;
                    done_q  <= 1'b1;
                end
            end else if (go_i) begin
                cyc_q <= 1'b1;
                we_q  <= we_i;
                adr_q <= adr_i;
                sel_q <= sel_i;
                dat_q <= dat_i;
            end
        end
    end

    assign wb.m_cyc_o = cyc_q;
    assign wb.m_stb_o = cyc_q;
    assign wb.m_we_o  = we_q;
    assign wb.m_adr_o = adr_q;
    assign wb.m_sel_o = sel_q;
    assign wb.m_dat_o = dat_q;

    assign rdata_o = rdata_q;
    assign done_o  = done_q;
    assign busy_o  = cyc_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Streams len bytes from a serial NOR flash (READ 0x03 + 24-bit address) by
// sequencing spi_master register accesses over Wishbone. The flash
// auto-increments its address, so only the byte count is tracked here.
module spi_flash_reader
    import spi_pkg::*;
#(
    parameter int         CS_INDEX = 0,
    parameter logic [7:0] SPI_CONF = 8'h00,
    parameter int         POLL_MAX = 1023
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [23:0]        addr_i,
    input  logic [15:0]        len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [7:0]         data_o,
    output logic               valid_o,
    input  logic               ready_i,
    spi_flash_reader_if.master wb
);

    localparam logic [9:0] POLL_LAST = 10'(POLL_MAX - 1);
    localparam logic [7:0] CS_SELECT = ~(8'h01 << CS_INDEX);

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [1:0]  cmd_idx_q, cmd_idx_d;
    logic        data_phase_q, data_phase_d;
    logic [9:0]  poll_cnt_q, poll_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        error_q, error_d;

    logic        acc_req;
    logic        acc_go;
    logic        acc_we;
    logic        acc_adr;
    logic [3:0]  acc_sel;
    logic [31:0] acc_wdat;
    logic [31:0] acc_rdata;
    logic        acc_done;
    logic        acc_busy;
    logic        rdata_unused;
    logic [7:0]  send_byte;

    spi_wb_access u_access (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .go_i    (acc_go),
        .we_i    (acc_we),
        .adr_i   (acc_adr),
        .sel_i   (acc_sel),
        .dat_i   (acc_wdat),
        .rdata_o (acc_rdata),
        .done_o  (acc_done),
        .busy_o  (acc_busy),
        .wb      (wb)
    );

    // Only the low byte and the two status bits of read data matter here.
    assign rdata_unused = ^acc_rdata[31:8];

    // Byte shifted out on SEND: opcode and address first, then dummy 0x00 per data byte.
    always_comb begin
        send_byte = 8'h00;
        if (!data_phase_q) begin
            case (cmd_idx_q)
                2'd0:    send_byte = OP_READ;
                2'd1:    send_byte = addr_q[23:16];
                2'd2:    send_byte = addr_q[15:8];
                default: send_byte = addr_q[7:0];
            endcase
        end
    end

    // Sequencer: next state, datapath updates and the bus access each state issues.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        cmd_idx_d    = cmd_idx_q;
        data_phase_d = data_phase_q;
        poll_cnt_d   = poll_cnt_q;
        data_d       = data_q;
        error_d      = error_q;
        acc_req      = 1'b0;
        acc_we       = 1'b0;
        acc_adr      = SPI_ADR_DATA;
        acc_sel      = 4'h0;
        acc_wdat     = 32'h0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d       = addr_i;
                    remaining_d  = len_i;
                    cmd_idx_d    = 2'd0;
                    data_phase_d = 1'b0;
                    error_d      = 1'b0;
                    state_d      = (len_i == 16'd0) ? S_DONE : S_CS_ON;
                end
            end
            S_CS_ON: begin
                acc_req  = 1'b1;
                acc_we   = 1'b1;
                acc_adr  = SPI_ADR_CTRL;
                acc_sel  = SEL_CTRL;
                acc_wdat = ctrl_word(CS_SELECT, SPI_CONF);
                if (acc_done) state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                acc_req = 1'b1;
                acc_adr = SPI_ADR_CTRL;
                if (acc_done) begin
                    if (!acc_rdata[ST_TXBUSY]) begin
                        state_d = S_SEND;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        error_d = 1'b1;
                        state_d = S_CS_OFF;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 10'd1;
                    end
                end
            end
            S_SEND: begin
                acc_req  = 1'b1;
                acc_we   = 1'b1;
                acc_sel  = SEL_DATA;
                acc_wdat = {24'h0, send_byte};
                if (acc_done) begin
                    if (data_phase_q) begin
                        state_d = S_WAIT_RX;
                    end else if (cmd_idx_q == 2'd3) begin
                        data_phase_d = 1'b1;
                        state_d      = S_FLUSH;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 2'd1;
                        state_d   = S_WAIT_TX;
                    end
                end
            end
            S_FLUSH: begin
                // Discarding read clears the rx_unread flag left by the command bytes.
                acc_req = 1'b1;
                if (acc_done) state_d = S_WAIT_TX;
            end
            S_WAIT_RX: begin
                acc_req = 1'b1;
                acc_adr = SPI_ADR_CTRL;
                if (acc_done) begin
                    if (!acc_rdata[ST_TXBUSY] && acc_rdata[ST_RXRDY]) begin
                        state_d = S_READ;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        error_d = 1'b1;
                        state_d = S_CS_OFF;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 10'd1;
                    end
                end
            end
            S_READ: begin
                acc_req = 1'b1;
                if (acc_done) begin
                    data_d  = acc_rdata[7:0];
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (ready_i) begin
                    remaining_d = remaining_q - 16'd1;
                    state_d     = (remaining_q == 16'd1) ? S_CS_OFF : S_WAIT_TX;
                end
            end
            S_CS_OFF: begin
                acc_req  = 1'b1;
                acc_we   = 1'b1;
                acc_adr  = SPI_ADR_CTRL;
                acc_sel  = SEL_CTRL;
                acc_wdat = ctrl_word(CS_ALL_OFF, SPI_CONF);
                if (acc_done) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Polling restarts from zero whenever a wait state is entered.
        if (state_d != state_q) poll_cnt_d = 10'd0;
    end

    // A new access may only launch once the previous one has fully retired.
    assign acc_go = acc_req && !acc_busy && !acc_done;

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            addr_q       <= 24'h0;
            remaining_q  <= 16'h0;
            cmd_idx_q    <= 2'd0;
            data_phase_q <= 1'b0;
            poll_cnt_q   <= 10'd0;
            data_q       <= 8'h00;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            cmd_idx_q    <= cmd_idx_d;
            data_phase_q <= data_phase_d;
            poll_cnt_q   <= poll_cnt_d;
            data_q       <= data_d;
            error_q      <= error_d;
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign valid_o = (state_q == S_EMIT);
    assign data_o  = data_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a behavioural spi_master + NOR flash slave on the
// Wishbone side, a randomly back-pressuring sink on the stream side, and
// expected MOSI/data sequences built straight from the flash READ protocol.
module tb_spi_flash_reader;

    localparam int         CS_INDEX = 3;
    localparam logic [7:0] SPI_CONF = 8'hA5;
    localparam int         POLL_MAX = 8;

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        start_i = 1'b0;
    logic [23:0] addr_i  = 24'h0;
    logic [15:0] len_i   = 16'h0;
    logic        ready_i = 1'b0;
    logic        busy_o, done_o, error_o, valid_o;
    logic [7:0]  data_o;

    spi_flash_reader_if bus ();

    spi_flash_reader #(
        .CS_INDEX (CS_INDEX),
        .SPI_CONF (SPI_CONF),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .addr_i  (addr_i),
        .len_i   (len_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .error_o (error_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .wb      (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Flash contents as a pure function of byte address.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h3C;
    endfunction

    // ---------------- spi_master + flash behavioural slave ----------------
    bit          stuck_busy = 1'b0;
    int          tx_busy_cnt;
    bit          rx_rdy;
    logic [7:0]  rx_data, pend_rx, sel_byte, mosi_b;
    int          xfer_idx;
    logic [23:0] fl_addr;
    logic [7:0]  mosi_q[$];
    int          status_reads, ctrl_wr_cnt, cs_err, cyc_cycles;
    int          proto_err = 0;
    logic [31:0] ctrl_first, ctrl_last;

    always @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.m_ack_i = 1'b0;
            bus.m_dat_i = 32'h0;
            tx_busy_cnt = 0;
            rx_rdy      = 1'b0;
            rx_data     = 8'h00;
            sel_byte    = 8'hFF;
            xfer_idx    = 0;
        end else begin
            if (tx_busy_cnt > 0) begin
                tx_busy_cnt--;
                if (tx_busy_cnt == 0) begin
                    rx_rdy  = 1'b1;
                    rx_data = pend_rx;
                end
            end
            if (bus.m_stb_o !== bus.m_cyc_o) proto_err++;
            if (bus.m_ack_i && bus.m_cyc_o) proto_err++;
            if (bus.m_cyc_o) cyc_cycles++;
            if (bus.m_cyc_o && bus.m_stb_o && !bus.m_ack_i) begin
                bus.m_ack_i = 1'b1;
                if (bus.m_we_o && bus.m_adr_o) begin
                    if (bus.m_sel_o[3]) sel_byte = bus.m_dat_o[31:24];
                    if (ctrl_wr_cnt == 0) ctrl_first = bus.m_dat_o;
                    ctrl_last = bus.m_dat_o;
                    ctrl_wr_cnt++;
                    if (sel_byte[CS_INDEX]) xfer_idx = 0;
                end else if (bus.m_we_o) begin
                    mosi_b = bus.m_dat_o[7:0];
                    if (sel_byte[CS_INDEX]) cs_err++;
                    mosi_q.push_back(mosi_b);
                    if (xfer_idx < 4) begin
                        if (xfer_idx == 1) fl_addr[23:16] = mosi_b;
                        if (xfer_idx == 2) fl_addr[15:8]  = mosi_b;
                        if (xfer_idx == 3) fl_addr[7:0]   = mosi_b;
                        pend_rx = 8'hFF;
                    end else begin
                        pend_rx = flash_byte(fl_addr);
                        fl_addr = fl_addr + 24'd1;
                    end
                    xfer_idx++;
                    tx_busy_cnt = $urandom_range(1, 10);
                end else if (bus.m_adr_o) begin
                    status_reads++;
                    bus.m_dat_i = {30'h0, (stuck_busy || tx_busy_cnt != 0), rx_rdy};
                end else begin
                    bus.m_dat_i = {24'h0, rx_data};
                    rx_rdy = 1'b0;
                end
            end else begin
                bus.m_ack_i = 1'b0;
            end
        end
    end

    // ---------------- stream sink ----------------
    bit         rand_ready = 1'b0;
    int         stall_at   = -1;
    int         stall_cnt  = 0;
    bit         hold_pending = 1'b0;
    logic [7:0] hold_data;
    logic [7:0] got_q[$];

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            ready_i      = 1'b0;
            hold_pending = 1'b0;
        end else begin
            if (valid_o && got_q.size() == stall_at && stall_cnt < 50) begin
                ready_i = 1'b0;
                stall_cnt++;
            end else begin
                ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (hold_pending) begin
                check("hold_valid", valid_o, 1'b1);
                check("hold_data", data_o, hold_data);
            end
            hold_pending = valid_o && !ready_i;
            hold_data    = data_o;
            if (valid_o && ready_i) got_q.push_back(data_o);
        end
    end

    // ---------------- helpers ----------------
    task automatic start_req(input logic [23:0] a, input logic [15:0] n);
        @(negedge clk_i);
        got_q.delete();
        mosi_q.delete();
        status_reads = 0;
        ctrl_wr_cnt  = 0;
        cyc_cycles   = 0;
        cs_err       = 0;
        addr_i  = a;
        len_i   = n;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (!done_o && t < budget) begin
            @(negedge clk_i);
            t++;
        end
        check("done_in_time", done_o, 1'b1);
        @(negedge clk_i);
        check("done_one_cycle", done_o, 1'b0);
        check("idle_after_done", busy_o, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  busy_o,  1'b0);
        check({tag, "_done"},  done_o,  1'b0);
        check({tag, "_error"}, error_o, 1'b0);
        check({tag, "_valid"}, valid_o, 1'b0);
        check({tag, "_data"},  data_o,  8'h00);
        check({tag, "_cyc"},   bus.m_cyc_o, 1'b0);
        check({tag, "_stb"},   bus.m_stb_o, 1'b0);
        check({tag, "_we"},    bus.m_we_o,  1'b0);
        check({tag, "_adr"},   bus.m_adr_o, 1'b0);
        check({tag, "_sel"},   bus.m_sel_o, 4'h0);
        check({tag, "_dat"},   bus.m_dat_o, 32'h0);
    endtask

    task automatic check_result(input logic [23:0] a, input logic [15:0] n);
        logic [7:0]  exp_mosi[$];
        logic [7:0]  cs_sel;
        logic [23:0] ai;
        exp_mosi.push_back(8'h03);
        exp_mosi.push_back(a[23:16]);
        exp_mosi.push_back(a[15:8]);
        exp_mosi.push_back(a[7:0]);
        for (int i = 0; i < int'(n); i++) exp_mosi.push_back(8'h00);
        cs_sel = 8'hFF;
        cs_sel[CS_INDEX] = 1'b0;

        check("mosi_len", mosi_q.size(), exp_mosi.size());
        for (int i = 0; i < exp_mosi.size() && i < mosi_q.size(); i++)
            check($sformatf("mosi[%0d]", i), mosi_q[i], exp_mosi[i]);
        check("rx_count", got_q.size(), n);
        for (int i = 0; i < int'(n) && i < got_q.size(); i++) begin
            ai = a + 24'(i);
            check($sformatf("data[%0d]", i), got_q[i], flash_byte(ai));
        end
        check("cs_low_during_xfer", cs_err, 0);
        check("ctrl_writes", ctrl_wr_cnt, 2);
        check("cs_on_word", ctrl_first, {cs_sel, SPI_CONF, 16'h0});
        check("cs_off_word", ctrl_last, {8'hFF, SPI_CONF, 16'h0});
        check("bus_protocol", proto_err, 0);
        check("no_error", error_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int          t;
        int          snap;
        logic [23:0] ra;
        logic [15:0] rn;

        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_quiet("reset");
        rst_n_i = 1'b1;

        // Basic read with the sink always ready.
        start_req(24'h012345, 16'd4);
        check("busy_after_start", busy_o, 1'b1);
        wait_done(4000);
        check_result(24'h012345, 16'd4);

        // Zero-length request: done next cycle, no bus traffic.
        start_req(24'h000100, 16'd0);
        check("len0_done", done_o, 1'b1);
        check("len0_busy", busy_o, 1'b1);
        @(negedge clk_i);
        check("len0_done_low", done_o, 1'b0);
        check("len0_no_cyc", cyc_cycles, 0);
        check("len0_no_error", error_o, 1'b0);

        // Sink stalls 50 cycles on the second byte.
        stall_at  = 1;
        stall_cnt = 0;
        start_req(24'h00ABCD, 16'd3);
        t = 0;
        while (stall_cnt < 1 && t < 3000) begin @(negedge clk_i); t++; end
        check("stall_reached", stall_cnt >= 1, 1'b1);
        snap = mosi_q.size();
        check("stall_mosi_snapshot", snap, 6);
        t = 0;
        while (stall_cnt < 50 && t < 200) begin @(negedge clk_i); t++; end
        check("stall_no_extra_sclk", mosi_q.size(), snap);
        check("stall_valid_held", valid_o, 1'b1);
        wait_done(4000);
        check_result(24'h00ABCD, 16'd3);
        stall_at = -1;

        // Randomized reads with random back-pressure; one extra start mid-transfer
        // and one wrap across the top of the address space.
        rand_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ra = (k == 5) ? 24'hFFFFFE : 24'($urandom);
            rn = 16'($urandom_range(1, 5));
            start_req(ra, rn);
            if (k == 1) begin
                repeat (20) @(negedge clk_i);
                addr_i  = ~ra;
                len_i   = 16'd9;
                start_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
            end
            wait_done(6000);
            check_result(ra, rn);
        end
        repeat (10) @(negedge clk_i);
        check("no_restart_from_ignored_start", busy_o, 1'b0);
        rand_ready = 1'b0;

        // tx busy never clears: abort after POLL_MAX polls, CS still released.
        stuck_busy = 1'b1;
        start_req(24'h123456, 16'd2);
        wait_done(2000);
        check("timeout_error", error_o, 1'b1);
        check("timeout_polls", status_reads, POLL_MAX);
        check("timeout_ctrl_writes", ctrl_wr_cnt, 2);
        check("timeout_cs_off", ctrl_last, {8'hFF, SPI_CONF, 16'h0});
        check("timeout_no_mosi", mosi_q.size(), 0);
        check("timeout_no_data", got_q.size(), 0);
        stuck_busy = 1'b0;
        repeat (3) @(negedge clk_i);
        check("error_sticky", error_o, 1'b1);
        start_req(24'h000010, 16'd2);
        check("error_cleared_on_start", error_o, 1'b0);
        wait_done(4000);
        check_result(24'h000010, 16'd2);

        // Reset during the second data byte, then a clean transfer.
        start_req(24'h0F0F00, 16'd4);
        t = 0;
        while (got_q.size() < 1 && t < 3000) begin @(negedge clk_i); t++; end
        check("first_byte_before_reset", got_q.size(), 1);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_quiet("midreset");
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        start_req(24'h00FF7E, 16'd3);
        wait_done(4000);
        check_result(24'h00FF7E, 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
